// File: rtl/lbp_pkg.sv
// Shared definitions for the LBP stream engine.
// Holds the FSM state encoding, the 3x3 window neighbour indices and the
// load lengths used by the fetch sequencer, plus a helper that maps an
// LBP code bit position to the window register that feeds it.
package lbp_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        TAIL    = 3'd2,
        COMPUTE = 3'd3,
        WRITE   = 3'd4,
        BORDER  = 3'd5,
        DONE    = 3'd6
    } state_e;

    // Window is stored row-major: index = 3*row + col inside the 3x3 block.
    localparam int NB_TL  = 0;
    localparam int NB_T   = 1;
    localparam int NB_TR  = 2;
    localparam int NB_L   = 3;
    localparam int CENTER = 4;
    localparam int NB_R   = 5;
    localparam int NB_BL  = 6;
    localparam int NB_B   = 7;
    localparam int NB_BR  = 8;

    localparam logic [3:0] FULL_LOAD  = 4'd9;
    localparam logic [3:0] SHIFT_LOAD = 4'd3;

    // Code bit b0..b7 -> window index; the center is skipped.
    function automatic int nb_index(input int bit_pos);
        case (bit_pos)
            0:       return NB_TL;
            1:       return NB_T;
            2:       return NB_TR;
            3:       return NB_L;
            4:       return NB_R;
            5:       return NB_BL;
            6:       return NB_B;
            7:       return NB_BR;
            default: return CENTER;
        endcase
    endfunction

endpackage

// File: rtl/lbp_stream_engine_if.sv
// Memory-side bus of the LBP stream engine.
// Groups the gray-frame read port (gray_req/gray_addr/gray_data, data one
// cycle after the request) and the LBP code write port
// (lbp_valid/lbp_addr/lbp_data). master = engine, slave = memory side.
interface lbp_stream_engine_if #(
    parameter int DW = 8,
    parameter int AW = 14
) ();

    logic          gray_req;
    logic [AW-1:0] gray_addr;
    logic [DW-1:0] gray_data;
    logic          lbp_valid;
    logic [AW-1:0] lbp_addr;
    logic [7:0]    lbp_data;

    modport master (
        output gray_req,
        output gray_addr,
        input  gray_data,
        output lbp_valid,
        output lbp_addr,
        output lbp_data
    );

    modport slave (
        input  gray_req,
        input  gray_addr,
        output gray_data,
        input  lbp_valid,
        input  lbp_addr,
        input  lbp_data
    );

endinterface

// File: rtl/lbp_code_calc.sv
// Combinational 3x3 LBP code calculator.
// Ports: win      - 9 window pixels, row-major, center at index 4
//        cfg_bias - bias added to the center before comparison
//        code     - 8-bit LBP code, bit b set iff neighbour >= center + bias
// The threshold is formed in DW+1 bits; a sum beyond the DW range can never
// be reached by a DW-bit neighbour, so such a window yields code 0.
module lbp_code_calc
    import lbp_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] win [9],
    input  logic [DW-1:0] cfg_bias,
    output logic [7:0]    code
);

    logic [DW:0] thresh_s;

    // Compare every neighbour against the biased center.
    always_comb begin
        thresh_s = {1'b0, win[CENTER]} + {1'b0, cfg_bias};
        code     = 8'h00;
        for (int b = 0; b < 8; b++) begin
            code[b] = ({1'b0, win[nb_index(b)]} >= thresh_s);
        end
    end

endmodule

// File: rtl/lbp_stream_engine.sv
// 3x3 Local Binary Pattern stream engine.
// Reads an IMG_W x IMG_H gray frame through mem (master side) and writes one
// LBP code per pixel in raster order.
// Ports: clk, reset (async, active-high)
//        gray_ready - frame available (level)
//        cfg_bias   - comparison bias, sampled at frame start
//        cfg_border - 1: border pixels also written with code 0
//        mem        - gray read port + lbp write port
//        finish     - frame complete, held until gray_ready drops
//        busy       - frame in progress
// Column 1 of each row does a full 9-read window load; every other interior
// pixel shifts the window left and reads only the new right column.
module lbp_stream_engine
    import lbp_pkg::*;
#(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int DW    = 8,
    parameter int AW    = 14
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                gray_ready,
    input  logic [DW-1:0]       cfg_bias,
    input  logic                cfg_border,
    lbp_stream_engine_if.master mem,
    output logic                finish,
    output logic                busy
);

    localparam logic [AW-1:0] ZERO_AW = AW'(0);
    localparam logic [AW-1:0] ONE_AW  = AW'(1);
    localparam logic [AW-1:0] TWO_AW  = AW'(2);
    localparam logic [AW-1:0] W_AW    = AW'(IMG_W);
    localparam logic [AW-1:0] W_LAST  = AW'(IMG_W - 1);
    localparam logic [AW-1:0] W_PEN   = AW'(IMG_W - 2);
    localparam logic [AW-1:0] H_LAST  = AW'(IMG_H - 1);
    localparam logic [AW-1:0] H_PEN   = AW'(IMG_H - 2);

    state_e        state_r, state_next_s;
    logic [AW-1:0] row_r, col_r, row_next_s, col_next_s;
    logic [AW-1:0] adv_row_s, adv_col_s;
    logic          is_last_s, adv_border_s;
    logic [3:0]    fcnt_r, fcnt_next_s, ccnt_r, cap_idx_s, load_len_s;
    logic          full_r, full_next_s, pend_r;
    logic [DW-1:0] bias_r;
    logic          border_r;
    logic [DW-1:0] win_r [9];
    logic [7:0]    code_s;

    logic          req_next_s, valid_next_s, finish_next_s, busy_next_s;
    logic [AW-1:0] dr_s, dc_s, rr_s, cc_s, gaddr_next_s, laddr_next_s;
    logic [7:0]    ldata_next_s;

    logic          gray_req_r, lbp_valid_r, finish_r, busy_r;
    logic [AW-1:0] gray_addr_r, lbp_addr_r;
    logic [7:0]    lbp_data_r;

    lbp_code_calc #(.DW(DW)) u_calc (
        .win      (win_r),
        .cfg_bias (bias_r),
        .code     (code_s)
    );

    // Next pixel in raster order and whether the current one ends the frame.
    always_comb begin
        if (border_r) begin
            is_last_s = (row_r == H_LAST) && (col_r == W_LAST);
            if (col_r == W_LAST) begin
                adv_row_s = row_r + ONE_AW;
                adv_col_s = ZERO_AW;
            end else begin
                adv_row_s = row_r;
                adv_col_s = col_r + ONE_AW;
            end
        end else begin
            is_last_s = (row_r == H_PEN) && (col_r == W_PEN);
            if (col_r == W_PEN) begin
                adv_row_s = row_r + ONE_AW;
                adv_col_s = ONE_AW;
            end else begin
                adv_row_s = row_r;
                adv_col_s = col_r + ONE_AW;
            end
        end
        adv_border_s = (adv_row_s == ZERO_AW) || (adv_row_s == H_LAST) ||
                       (adv_col_s == ZERO_AW) || (adv_col_s == W_LAST);
        load_len_s   = full_r ? FULL_LOAD : SHIFT_LOAD;
    end

    // Next-state and next-counter logic.
    always_comb begin
        state_next_s = state_r;
        row_next_s   = row_r;
        col_next_s   = col_r;
        fcnt_next_s  = fcnt_r;
        full_next_s  = full_r;
        case (state_r)
            IDLE: begin
                if (gray_ready && !finish_r) begin
                    if (cfg_border) begin
                        row_next_s   = ZERO_AW;
                        col_next_s   = ZERO_AW;
                        state_next_s = BORDER;
                    end else begin
                        row_next_s   = ONE_AW;
                        col_next_s   = ONE_AW;
                        fcnt_next_s  = 4'd0;
                        full_next_s  = 1'b1;
                        state_next_s = FETCH;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            FETCH: begin
                if (fcnt_r == load_len_s - 4'd1) begin
                    state_next_s = TAIL;
                end else begin
                    fcnt_next_s = fcnt_r + 4'd1;
                end
            end
            TAIL:    state_next_s = COMPUTE;
            COMPUTE: state_next_s = WRITE;
            WRITE, BORDER: begin
                if (is_last_s) begin
                    state_next_s = DONE;
                end else begin
                    row_next_s = adv_row_s;
                    col_next_s = adv_col_s;
                    if (border_r && adv_border_s) begin
                        state_next_s = BORDER;
                    end else begin
                        state_next_s = FETCH;
                        fcnt_next_s  = 4'd0;
                        full_next_s  = (adv_col_s == ONE_AW);
                    end
                end
            end
            DONE: begin
                if (!gray_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Pixel/fetch counters and frame configuration captured at start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_r    <= ZERO_AW;
            col_r    <= ZERO_AW;
            fcnt_r   <= 4'd0;
            full_r   <= 1'b0;
            bias_r   <= '0;
            border_r <= 1'b0;
        end else begin
            row_r  <= row_next_s;
            col_r  <= col_next_s;
            fcnt_r <= fcnt_next_s;
            full_r <= full_next_s;
            if (state_r == IDLE && state_next_s != IDLE) begin
                bias_r   <= cfg_bias;
                border_r <= cfg_border;
            end
        end
    end

    // Capture slot: full load fills row-major, shift load fills the right column.
    always_comb begin
        if (full_r) begin
            cap_idx_s = ccnt_r;
        end else begin
            cap_idx_s = 4'(ccnt_r * 4'd3 + 4'd2);
        end
    end

    // Window registers: shift on a shift-load start, capture returning data.
    // pend_r marks the cycle in which a previous request's data is on gray_data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_r <= 1'b0;
            ccnt_r <= 4'd0;
            for (int i = 0; i < 9; i++) begin
                win_r[i] <= '0;
            end
        end else begin
            pend_r <= gray_req_r;
            if (state_r != FETCH && state_next_s == FETCH) begin
                ccnt_r <= 4'd0;
            end
            if (state_r == WRITE && state_next_s == FETCH && !full_next_s) begin
                for (int r = 0; r < 3; r++) begin
                    win_r[3*r]     <= win_r[3*r + 1];
                    win_r[3*r + 1] <= win_r[3*r + 2];
                end
            end
            if (pend_r) begin
                win_r[cap_idx_s] <= mem.gray_data;
                ccnt_r           <= ccnt_r + 4'd1;
            end
        end
    end

    // Next output values, derived from the upcoming state and pixel.
    always_comb begin
        if (full_next_s) begin
            if (fcnt_next_s < 4'd3) begin
                dr_s = ZERO_AW;
                dc_s = AW'(fcnt_next_s);
            end else if (fcnt_next_s < 4'd6) begin
                dr_s = ONE_AW;
                dc_s = AW'(fcnt_next_s - 4'd3);
            end else begin
                dr_s = TWO_AW;
                dc_s = AW'(fcnt_next_s - 4'd6);
            end
        end else begin
            dr_s = AW'(fcnt_next_s);
            dc_s = TWO_AW;
        end
        rr_s          = row_next_s + dr_s - ONE_AW;
        cc_s          = col_next_s + dc_s - ONE_AW;
        gaddr_next_s  = rr_s * W_AW + cc_s;
        laddr_next_s  = row_next_s * W_AW + col_next_s;
        req_next_s    = (state_next_s == FETCH);
        valid_next_s  = (state_next_s == WRITE) || (state_next_s == BORDER);
        ldata_next_s  = (state_next_s == BORDER) ? 8'h00 : code_s;
        finish_next_s = (state_next_s == DONE);
        busy_next_s   = (state_next_s == FETCH)   || (state_next_s == TAIL)  ||
                        (state_next_s == COMPUTE) || (state_next_s == WRITE) ||
                        (state_next_s == BORDER);
    end

    // Output registers; addresses and data hold while their strobe is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gray_req_r  <= 1'b0;
            gray_addr_r <= ZERO_AW;
            lbp_valid_r <= 1'b0;
            lbp_addr_r  <= ZERO_AW;
            lbp_data_r  <= 8'h00;
            finish_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            gray_req_r  <= req_next_s;
            lbp_valid_r <= valid_next_s;
            finish_r    <= finish_next_s;
            busy_r      <= busy_next_s;
            if (req_next_s) begin
                gray_addr_r <= gaddr_next_s;
            end
            if (valid_next_s) begin
                lbp_addr_r <= laddr_next_s;
                lbp_data_r <= ldata_next_s;
            end
        end
    end

    assign mem.gray_req  = gray_req_r;
    assign mem.gray_addr = gray_addr_r;
    assign mem.lbp_valid = lbp_valid_r;
    assign mem.lbp_addr  = lbp_addr_r;
    assign mem.lbp_data  = lbp_data_r;
    assign finish        = finish_r;
    assign busy          = busy_r;

endmodule
